rom_window_ctrl: RTL and testbench
==================================

ROM_WINDOW_CTRL -- requirements
Module: rom_window_ctrl

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning:
- ADDR_W, 7, decoded address width (ADDR[23:17] at default)
- WIN_BASE, 7'h00, first decoded address in window (inclusive)
- WIN_LIMIT, 7'h3F, last decoded address in window (inclusive)
- RD_WAIT, 2, read wait cycles, range 0..15
- WR_WAIT, 3, write wait cycles, range 0..15
- REC_CYC, 1, recovery cycles after cycle end, range 0..7
REQ-002 SHALL provide ports, one per line: name, direction, width, meaning:
- CLK, in, 1, sole clock; all state changes on rising edge
- RESET, in, 1, asynchronous active-high reset
- ADDR, in, ADDR_W, decoded upper address
- READ, in, 1, 1 = read, 0 = write
- FCS_n, in, 1, bus cycle strobe, active-low
- slave_cycle, in, 1, board addressed as slave
- configured, in, 1, autoconfig complete
- shutup, in, 1, board disabled
- write_unlock, in, 1, software flash-write enable
- rom_selected, out, 1, combinational window hit
- rom_dtack, out, 1, registered transfer acknowledge
- ROM_CE_n, ROM_OE_n, ROM_WE_n, out, 1 each, registered ROM strobes, active-low
- busy, out, 1, FSM not in IDLE
REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 rom_selected SHALL equal slave_cycle AND WIN_BASE <= ADDR <= WIN_LIMIT, both bounds inclusive, independent of shutup.
REQ-005 FSM states SHALL be IDLE, WAIT, ACK, RECOV.
REQ-006 IDLE: on an edge sampling rom_selected=1, FCS_n=0, shutup=0 -> latch READ as dir, load counter with RD_WAIT (dir=1) or WR_WAIT (dir=0), go WAIT; otherwise stay.
REQ-007 WAIT: counter decrements each edge; on the edge where counter=0 -> ACK.
REQ-008 rom_dtack SHALL rise exactly WAIT_n+1 edges after the accepting edge, where WAIT_n is RD_WAIT or WR_WAIT per dir; with a wait value of 0, rom_dtack rises on the edge after acceptance.
REQ-009 ACK: rom_dtack=1 held until an edge samples FCS_n=1 -> rom_dtack=0, go RECOV if REC_CYC>0, else IDLE.
REQ-010 RECOV: stay for REC_CYC edges, then IDLE; no new cycle SHALL be accepted before IDLE.
REQ-011 ROM_CE_n SHALL be 0 in WAIT and ACK, 1 otherwise.
REQ-012 ROM_OE_n SHALL be 0 in WAIT and ACK when dir=1.
REQ-013 ROM_WE_n SHALL be 0 in WAIT only, when dir=0 AND configured AND write_unlock, all sampled at acceptance; WE_n SHALL go high on entry to ACK to provide data hold.
REQ-014 A write rejected by REQ-013 SHALL still complete with rom_dtack, with ROM_WE_n held high.
REQ-015 Abort: FCS_n=1 sampled in WAIT -> all strobes high, no rom_dtack, go RECOV or IDLE per REQ-009.
REQ-016 shutup=1 sampled in WAIT or ACK SHALL act as abort, with rom_dtack forced 0 on that edge.
REQ-017 The counter SHALL be 4 bits and SHALL never underflow.

Reset
REQ-018 RESET=1 SHALL force state IDLE, counter=0, dir=1, rom_dtack=0, ROM_CE_n=ROM_OE_n=ROM_WE_n=1, busy=0 immediately, including mid-cycle.
REQ-019 After RESET deasserts, an access whose FCS_n is already low SHALL be accepted on the first edge at which REQ-006 holds.

Structure
REQ-020 A shared package SHALL hold the FSM state enum and the parameter range limits (max wait 15, max recovery 7).
REQ-021 One sub-module, rom_wait_counter, SHALL implement the load/decrement/zero-flag counter, reused for WAIT and RECOV.

Verification
REQ-022 Read, ADDR=7'h10, RD_WAIT=2 -> CE_n/OE_n low for 4 cycles, rom_dtack rises 3 edges after acceptance, falls on the edge sampling FCS_n=1, busy clears after 1 RECOV cycle.
REQ-023 Write with configured=1, write_unlock=1, WR_WAIT=3 -> ROM_WE_n low for exactly 4 cycles, high in ACK; rom_dtack=1.
REQ-024 Write with write_unlock=0 -> ROM_WE_n stays 1 throughout; rom_dtack still asserts.
REQ-025 Window bounds: ADDR=7'h3F -> rom_selected=1; ADDR=7'h40 -> rom_selected=0, no strobes, busy=0.
REQ-026 FCS_n rises, or shutup asserts, during WAIT -> no rom_dtack, strobes high next edge; back-to-back request is accepted only after REC_CYC cycles.
REQ-027 RESET pulse during ACK -> all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/rom_window_ctrl_pkg.sv
// Shared types and limits for the ROM window controller and its counter.
package rom_window_ctrl_pkg;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;
    localparam int MAX_REC  = 7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        RECOV
    } state_t;

endpackage

// File: rtl/rom_wait_counter.sv
// Loadable down-counter with a zero flag, shared by the WAIT and RECOV phases.
module rom_wait_counter
    import rom_window_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rom_window_ctrl.sv
// Address-window decode and wait-state FSM driving the flash ROM strobes and DTACK.
module rom_window_ctrl
    import rom_window_ctrl_pkg::*;
#(
    parameter int              ADDR_W    = 7,
    parameter logic [ADDR_W-1:0] WIN_BASE  = 7'h00,
    parameter logic [ADDR_W-1:0] WIN_LIMIT = 7'h3F,
    parameter int              RD_WAIT   = 2,
    parameter int              WR_WAIT   = 3,
    parameter int              REC_CYC   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              READ,
    input  logic              FCS_n,
    input  logic              slave_cycle,
    input  logic              configured,
    input  logic              shutup,
    input  logic              write_unlock,
    output logic              rom_selected,
    output logic              rom_dtack,
    output logic              ROM_CE_n,
    output logic              ROM_OE_n,
    output logic              ROM_WE_n,
    output logic              busy
);

    localparam int RD_CLAMP  = (RD_WAIT > MAX_WAIT) ? MAX_WAIT : RD_WAIT;
    localparam int WR_CLAMP  = (WR_WAIT > MAX_WAIT) ? MAX_WAIT : WR_WAIT;
    localparam int REC_CLAMP = (REC_CYC > MAX_REC) ? MAX_REC : REC_CYC;

    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CLAMP);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CLAMP);
    // RECOV exits on the zero flag, so it is loaded one short of its length.
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'((REC_CLAMP > 0) ? REC_CLAMP - 1 : 0);
    localparam bit               HAS_REC  = (REC_CLAMP > 0);
    localparam state_t           END_STATE = HAS_REC ? RECOV : IDLE;

    localparam logic [ADDR_W-1:0] WIN_SPAN = WIN_LIMIT - WIN_BASE;

    state_t           state, state_d;
    logic             dir, dir_d;
    logic             we_en, we_en_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             dtack_d, ce_n_d, oe_n_d, we_n_d;
    logic [ADDR_W-1:0] win_off;

    // Offset compare covers both inclusive bounds in one unsigned test.
    assign win_off      = ADDR - WIN_BASE;
    assign rom_selected = slave_cycle && (win_off <= WIN_SPAN);
    assign busy         = (state != IDLE);

    rom_wait_counter u_counter (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            dir       <= 1'b1;
            we_en     <= 1'b0;
            rom_dtack <= 1'b0;
            ROM_CE_n  <= 1'b1;
            ROM_OE_n  <= 1'b1;
            ROM_WE_n  <= 1'b1;
        end else begin
            state     <= state_d;
            dir       <= dir_d;
            we_en     <= we_en_d;
            rom_dtack <= dtack_d;
            ROM_CE_n  <= ce_n_d;
            ROM_OE_n  <= oe_n_d;
            ROM_WE_n  <= we_n_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state;
        dir_d        = dir;
        we_en_d      = we_en;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (rom_selected && !FCS_n && !shutup) begin
                    state_d      = WAIT;
                    dir_d        = READ;
                    we_en_d      = !READ && configured && write_unlock;
                    cnt_load     = 1'b1;
                    cnt_load_val = READ ? RD_LOAD : WR_LOAD;
                end
            end
            WAIT: begin
                if (FCS_n || shutup) begin
                    state_d      = END_STATE;
                    cnt_load     = HAS_REC;
                    cnt_load_val = REC_LOAD;
                end else if (cnt_zero) begin
                    state_d = ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ACK: begin
                if (FCS_n || shutup) begin
                    state_d      = END_STATE;
                    cnt_load     = HAS_REC;
                    cnt_load_val = REC_LOAD;
                end
            end
            RECOV: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state, so they change on the same edge as the state.
    always_comb begin
        dtack_d = (state_d == ACK);
        ce_n_d  = !((state_d == WAIT) || (state_d == ACK));
        oe_n_d  = !(((state_d == WAIT) || (state_d == ACK)) && dir_d);
        we_n_d  = !((state_d == WAIT) && !dir_d && we_en_d);
    end

endmodule

// File: tb/tb_rom_window_ctrl.sv
// Scoreboard bench for rom_window_ctrl at default parameters.
module tb_rom_window_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [6:0] ADDR;
    logic       READ, FCS_n, slave_cycle, configured, shutup, write_unlock;
    logic       rom_selected, rom_dtack, ROM_CE_n, ROM_OE_n, ROM_WE_n, busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int lat;
        int dtack_cyc;
        int ce;
        int oe;
        int we;
        int rec;
    } exp_t;

    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    rom_window_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDR         (ADDR),
        .READ         (READ),
        .FCS_n        (FCS_n),
        .slave_cycle  (slave_cycle),
        .configured   (configured),
        .shutup       (shutup),
        .write_unlock (write_unlock),
        .rom_selected (rom_selected),
        .rom_dtack    (rom_dtack),
        .ROM_CE_n     (ROM_CE_n),
        .ROM_OE_n     (ROM_OE_n),
        .ROM_WE_n     (ROM_WE_n),
        .busy         (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dtack"}, int'(rom_dtack), 0);
        check({tag, "_ce_n"},  int'(ROM_CE_n),  1);
        check({tag, "_oe_n"},  int'(ROM_OE_n),  1);
        check({tag, "_we_n"},  int'(ROM_WE_n),  1);
        check({tag, "_busy"},  int'(busy),      0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        if (busy) check({tag, "_idle_timeout"}, 1, 0);
    endtask

    // Called just after a sample point with the FSM idle; abort_at counts edges after acceptance.
    task automatic do_access(input string tag, input logic [6:0] a, input logic rd,
                             input logic cfg, input logic unl, input int abort_at,
                             input logic use_shut);
        exp_t e, o;
        int   wait_n, acc_k;
        logic done, wr_ok;
        wait_n = rd ? 2 : 3;
        wr_ok  = !rd && cfg && unl;
        e = '{-1, 0, 0, 0, 0, 0};
        if (a <= 7'h3F) begin
            e.rec = 1;
            if (abort_at > 0) begin
                e.ce = abort_at;
                e.oe = rd ? abort_at : 0;
                e.we = wr_ok ? abort_at : 0;
            end else begin
                e.lat       = wait_n + 1;
                e.dtack_cyc = 1;
                e.ce        = wait_n + 2;
                e.oe        = rd ? wait_n + 2 : 0;
                e.we        = wr_ok ? wait_n + 1 : 0;
            end
        end
        sb_q.push_back(e);

        ADDR = a; READ = rd; configured = cfg; write_unlock = unl;
        slave_cycle = 1'b1; FCS_n = 1'b0;
        o = '{-1, 0, 0, 0, 0, 0};
        acc_k = -1;
        done  = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge CLK); #1;
            if (busy && acc_k < 0) acc_k = k;
            if (!ROM_CE_n) o.ce++;
            if (!ROM_OE_n) o.oe++;
            if (!ROM_WE_n) o.we++;
            if (busy && ROM_CE_n) o.rec++;
            if (rom_dtack) begin
                o.dtack_cyc++;
                if (o.lat < 0) o.lat = k - acc_k;
                FCS_n = 1'b1;
            end
            if (acc_k > 0 && abort_at > 0 && k == acc_k + abort_at - 1) begin
                if (use_shut) shutup = 1'b1;
                else          FCS_n  = 1'b1;
            end
            if ((acc_k > 0 && !busy) || (acc_k < 0 && k >= 4)) done = 1'b1;
        end
        FCS_n = 1'b1; shutup = 1'b0; slave_cycle = 1'b0;
        if (!done) check({tag, "_timeout"}, 0, 1);

        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_lat"},   o.lat,       e.lat);
            check({tag, "_dtack"}, o.dtack_cyc, e.dtack_cyc);
            check({tag, "_ce"},    o.ce,        e.ce);
            check({tag, "_oe"},    o.oe,        e.oe);
            check({tag, "_we"},    o.we,        e.we);
            check({tag, "_rec"},   o.rec,       e.rec);
        end
    endtask

    initial begin
        RESET = 1'b1; ADDR = '0; READ = 1'b1; FCS_n = 1'b1; slave_cycle = 1'b0;
        configured = 1'b0; shutup = 1'b0; write_unlock = 1'b0;
        #3;
        check_reset_outputs("por");
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;

        // Window decode is combinational and ignores shutup.
        slave_cycle = 1'b1;
        ADDR = 7'h3F; #1; check("sel_3f", int'(rom_selected), 1);
        ADDR = 7'h40; #1; check("sel_40", int'(rom_selected), 0);
        ADDR = 7'h00; #1; check("sel_00", int'(rom_selected), 1);
        shutup = 1'b1; ADDR = 7'h20; #1; check("sel_shut", int'(rom_selected), 1);
        shutup = 1'b0; slave_cycle = 1'b0; #1; check("sel_noslave", int'(rom_selected), 0);
        @(posedge CLK); #1;

        do_access("rd10",     7'h10, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        do_access("wr_en",    7'h20, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        do_access("wr_lock",  7'h20, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        do_access("wr_nocfg", 7'h05, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        do_access("rd3f",     7'h3F, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_access("miss40",   7'h40, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        do_access("ab_fcs",   7'h10, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        do_access("ab_shut",  7'h20, 1'b0, 1'b1, 1'b1, 3, 1'b1);
        do_access("ab_last",  7'h11, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_access("rand", 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        // Back-to-back: FCS_n held low across a shutup abort must wait out RECOV.
        ADDR = 7'h10; READ = 1'b1; slave_cycle = 1'b1; FCS_n = 1'b0;
        @(posedge CLK); #1; check("b2b_acc", int'(busy), 1);
        shutup = 1'b1;
        @(posedge CLK); #1;
        check("b2b_ab_ce",    int'(ROM_CE_n),  1);
        check("b2b_ab_dtack", int'(rom_dtack), 0);
        check("b2b_recov",    int'(busy),      1);
        shutup = 1'b0;
        @(posedge CLK); #1; check("b2b_idle", int'(busy), 0);
        @(posedge CLK); #1;
        check("b2b_reacc",    int'(busy),      1);
        check("b2b_reacc_ce", int'(ROM_CE_n),  0);
        FCS_n = 1'b1;
        wait_idle("b2b");

        // Reset in ACK takes effect without a clock edge; held FCS_n is accepted right after.
        ADDR = 7'h10; READ = 1'b1; slave_cycle = 1'b1; FCS_n = 1'b0;
        for (int n = 0; n < 10 && !rom_dtack; n++) begin
            @(posedge CLK); #1;
        end
        check("rst_reach_ack", int'(rom_dtack), 1);
        #1 RESET = 1'b1;
        #1 check_reset_outputs("rst_ack");
        #1 RESET = 1'b0;
        @(posedge CLK); #1;
        check("rst_reacc",    int'(busy),     1);
        check("rst_reacc_oe", int'(ROM_OE_n), 0);
        FCS_n = 1'b1; slave_cycle = 1'b0;
        wait_idle("rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
